// File: rtl/midi_pkg.sv
// Shared types and constants for the multi-port MIDI message builder.
package midi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT1 = 2'd1,
    ST_WAIT2 = 2'd2,
    ST_SYSEX = 2'd3
  } parse_state_e;

  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  // Number of data bytes following a channel status byte.
  function automatic logic [1:0] msg_len(input logic [7:0] status);
    return (status[7:4] == 4'hC || status[7:4] == 4'hD) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/midi_port_parser.sv
// Per-port MIDI parser: running status, SysEx tracking and the
// eligibility / pop decision for the byte at the head of its FIFO.
module midi_port_parser
  import midi_pkg::*;
(
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       grant_i,
  input  logic       in_valid_i,
  input  logic [7:0] byte_i,
  input  logic       lock_other_i,
  output logic       eligible_o,
  output logic       pop_o,
  output logic       emit_cmd_o,
  output logic       emit_sysex_o,
  output logic       emit_rt_o,
  output logic       lock_acq_o,
  output logic       lock_rel_o,
  output logic [7:0] cmd_head_o,
  output logic [6:0] cmd_d1_o,
  output logic [6:0] cmd_d2_o,
  output logic [7:0] sysex_data_o,
  output logic       sysex_last_o
);

  parse_state_e state_q, state_d;
  logic [7:0]   rs_q, rs_d;
  logic         rs_vld_q, rs_vld_d;
  logic [6:0]   d1_q, d1_d;

  // Decode the head byte and decide what a grant does this cycle.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d      = state_q;
    rs_d         = rs_q;
    rs_vld_d     = rs_vld_q;
    d1_d         = d1_q;
    pop_o        = 1'b0;
    emit_cmd_o   = 1'b0;
    emit_sysex_o = 1'b0;
    emit_rt_o    = 1'b0;
    lock_acq_o   = 1'b0;
    lock_rel_o   = 1'b0;
    cmd_head_o   = rs_q;
    cmd_d1_o     = d1_q;
    cmd_d2_o     = byte_i[6:0];
    sysex_data_o = byte_i;
    sysex_last_o = 1'b0;

    eligible_o = in_valid_i &
                 ~(lock_other_i & ((state_q == ST_SYSEX) || (byte_i == SYSEX_START)));

    if (grant_i) begin
      if (byte_i >= RT_MIN) begin
        pop_o     = 1'b1;
        emit_rt_o = 1'b1;
      end else if (state_q == ST_SYSEX) begin
        emit_sysex_o = 1'b1;
        if (!byte_i[7]) begin
          pop_o = 1'b1;
        end else begin
          // F7 is consumed; any other status closes the SysEx without popping.
          pop_o        = (byte_i == SYSEX_END);
          sysex_data_o = SYSEX_END;
          sysex_last_o = 1'b1;
          lock_rel_o   = 1'b1;
          state_d      = ST_IDLE;
        end
      end else begin
        pop_o = 1'b1;
        if (byte_i == SYSEX_START) begin
          emit_sysex_o = 1'b1;
          lock_acq_o   = 1'b1;
          rs_vld_d     = 1'b0;
          state_d      = ST_SYSEX;
        end else if (byte_i == SYSEX_END) begin
          state_d = state_q;
        end else if (byte_i > SYSEX_START) begin
          rs_vld_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (byte_i[7]) begin
          rs_d     = byte_i;
          rs_vld_d = 1'b1;
          state_d  = ST_WAIT1;
        end else if (state_q == ST_WAIT2) begin
          emit_cmd_o = 1'b1;
          state_d    = ST_IDLE;
        end else if (state_q == ST_WAIT1 || rs_vld_q) begin
          d1_d = byte_i[6:0];
          if (msg_len(rs_q) == 2'd1) begin
            emit_cmd_o = 1'b1;
            cmd_d1_o   = byte_i[6:0];
            cmd_d2_o   = 7'd0;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_WAIT2;
          end
        end
      end
    end
  end

  // Parser state, running status and first data byte.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      rs_q     <= 8'h00;
      rs_vld_q <= 1'b0;
      d1_q     <= 7'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q  <= state_d;
      rs_q     <= rs_d;
      rs_vld_q <= rs_vld_d;
      d1_q     <= d1_d;
    end
  end

endmodule

// File: rtl/midi_multi_builder.sv
// Multi-port MIDI message builder: round-robin arbiter over per-port
// parsers, SysEx ownership lock and registered FIFO write outputs.
module midi_multi_builder
  import midi_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NUM_PORTS-1:0]   in_valid,
  input  logic [8*NUM_PORTS-1:0] in_data,
  output logic [NUM_PORTS-1:0]   in_rd,
  input  logic [15:0]            ch_mask,
  output logic                   cmd_fifo_wr,
  output logic [7:0]             cmd_fifo_head,
  output logic [6:0]             cmd_fifo_data1,
  output logic [6:0]             cmd_fifo_data2,
  output logic [PORT_W-1:0]      cmd_fifo_port,
  input  logic                   cmd_fifo_busy,
  output logic                   sysex_fifo_wr,
  output logic [7:0]             sysex_fifo_data,
  output logic                   sysex_fifo_last,
  output logic [PORT_W-1:0]      sysex_fifo_port,
  input  logic                   sysex_fifo_busy,
  output logic                   rt_valid,
  output logic [7:0]             rt_data,
  output logic [PORT_W-1:0]      rt_port
);

  localparam logic [PORT_W:0] NP = NUM_PORTS[PORT_W:0];

  logic [NUM_PORTS-1:0] p_elig, p_pop, p_cmd, p_sx, p_rt, p_acq, p_rel, p_last;
  logic [NUM_PORTS-1:0] lock_other, grant, avail;
  logic [7:0]           p_head [NUM_PORTS];
  logic [6:0]           p_d1   [NUM_PORTS];
  logic [6:0]           p_d2   [NUM_PORTS];
  logic [7:0]           p_sxd  [NUM_PORTS];

  logic [PORT_W-1:0] last_grant_q, lock_owner_q, gnt_idx;
  logic              lock_vld_q, gnt_any;
  logic [PORT_W:0]   cand;

  logic              cmd_wr_q, sx_wr_q, sx_last_q, rt_vld_q;
  logic [7:0]        cmd_head_q, sx_data_q, rt_data_q;
  logic [6:0]        cmd_d1_q, cmd_d2_q;
  logic [PORT_W-1:0] cmd_port_q, sx_port_q, rt_port_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign lock_other[p] = lock_vld_q && (lock_owner_q != PORT_W'(p));

    midi_port_parser u_parser (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .grant_i      (grant[p]),
      .in_valid_i   (in_valid[p]),
      .byte_i       (in_data[8*p +: 8]),
      .lock_other_i (lock_other[p]),
      .eligible_o   (p_elig[p]),
      .pop_o        (p_pop[p]),
      .emit_cmd_o   (p_cmd[p]),
      .emit_sysex_o (p_sx[p]),
      .emit_rt_o    (p_rt[p]),
      .lock_acq_o   (p_acq[p]),
      .lock_rel_o   (p_rel[p]),
      .cmd_head_o   (p_head[p]),
      .cmd_d1_o     (p_d1[p]),
      .cmd_d2_o     (p_d2[p]),
      .sysex_data_o (p_sxd[p]),
      .sysex_last_o (p_last[p])
    );
  end

  assign avail = p_elig & ~{NUM_PORTS{cmd_fifo_busy | sysex_fifo_busy}};
  assign in_rd = p_pop;

  // Round-robin search starting one past the last granted port.
  always_comb begin
    grant   = '0;
    gnt_idx = last_grant_q;
    gnt_any = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, last_grant_q} + (PORT_W+1)'(i + 1);
      if (cand >= NP) cand = cand - NP;
      if (!gnt_any && avail[cand[PORT_W-1:0]]) begin
        gnt_any                 = 1'b1;
        gnt_idx                 = cand[PORT_W-1:0];
        grant[cand[PORT_W-1:0]] = 1'b1;
      end
    end
  end

  // Arbiter history, SysEx lock and registered write strobes/fields.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      last_grant_q <= PORT_W'(NUM_PORTS - 1);
      lock_vld_q   <= 1'b0;
      lock_owner_q <= '0;
      cmd_wr_q     <= 1'b0;
      cmd_head_q   <= 8'h00;
      cmd_d1_q     <= 7'd0;
      cmd_d2_q     <= 7'd0;
      cmd_port_q   <= '0;
      sx_wr_q      <= 1'b0;
      sx_data_q    <= 8'h00;
      sx_last_q    <= 1'b0;
      sx_port_q    <= '0;
      rt_vld_q     <= 1'b0;
      rt_data_q    <= 8'h00;
      rt_port_q    <= '0;
    end else begin
      cmd_wr_q <= 1'b0;
      sx_wr_q  <= 1'b0;
      rt_vld_q <= 1'b0;
      if (gnt_any) begin
        last_grant_q <= gnt_idx;
        if (p_cmd[gnt_idx] && ch_mask[p_head[gnt_idx][3:0]]) begin
          cmd_wr_q   <= 1'b1;
          cmd_head_q <= p_head[gnt_idx];
          cmd_d1_q   <= p_d1[gnt_idx];
          cmd_d2_q   <= p_d2[gnt_idx];
          cmd_port_q <= gnt_idx;
        end
        if (p_sx[gnt_idx]) begin
          sx_wr_q   <= 1'b1;
          sx_data_q <= p_sxd[gnt_idx];
          sx_last_q <= p_last[gnt_idx];
          sx_port_q <= gnt_idx;
        end
        if (p_rt[gnt_idx]) begin
          rt_vld_q  <= 1'b1;
          rt_data_q <= in_data[8*gnt_idx +: 8];
          rt_port_q <= gnt_idx;
        end
        if (p_acq[gnt_idx]) begin
          lock_vld_q   <= 1'b1;
          lock_owner_q <= gnt_idx;
        end else if (p_rel[gnt_idx]) begin
          lock_vld_q <= 1'b0;
        end
      end
    end
  end

  assign cmd_fifo_wr     = cmd_wr_q;
  assign cmd_fifo_head   = cmd_head_q;
  assign cmd_fifo_data1  = cmd_d1_q;
  assign cmd_fifo_data2  = cmd_d2_q;
  assign cmd_fifo_port   = cmd_port_q;
  assign sysex_fifo_wr   = sx_wr_q;
  assign sysex_fifo_data = sx_data_q;
  assign sysex_fifo_last = sx_last_q;
  assign sysex_fifo_port = sx_port_q;
  assign rt_valid        = rt_vld_q;
  assign rt_data         = rt_data_q;
  assign rt_port         = rt_port_q;

endmodule

// File: tb/tb_midi_multi_builder.sv
// Scoreboard bench for midi_multi_builder with two FWFT byte sources.
module tb_midi_multi_builder;

  localparam int NP = 2;
  localparam int PW = 1;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [NP-1:0]   in_valid = '0;
  logic [8*NP-1:0] in_data = '0;
  logic [NP-1:0]   in_rd;
  logic [15:0]     ch_mask = 16'hFFFF;
  logic            cmd_fifo_wr, sysex_fifo_wr, sysex_fifo_last, rt_valid;
  logic [7:0]      cmd_fifo_head, sysex_fifo_data, rt_data;
  logic [6:0]      cmd_fifo_data1, cmd_fifo_data2;
  logic [PW-1:0]   cmd_fifo_port, sysex_fifo_port, rt_port;
  logic            cmd_fifo_busy = 1'b0;
  logic            sysex_fifo_busy = 1'b0;

  midi_multi_builder #(.NUM_PORTS(NP)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_rd           (in_rd),
    .ch_mask         (ch_mask),
    .cmd_fifo_wr     (cmd_fifo_wr),
    .cmd_fifo_head   (cmd_fifo_head),
    .cmd_fifo_data1  (cmd_fifo_data1),
    .cmd_fifo_data2  (cmd_fifo_data2),
    .cmd_fifo_port   (cmd_fifo_port),
    .cmd_fifo_busy   (cmd_fifo_busy),
    .sysex_fifo_wr   (sysex_fifo_wr),
    .sysex_fifo_data (sysex_fifo_data),
    .sysex_fifo_last (sysex_fifo_last),
    .sysex_fifo_port (sysex_fifo_port),
    .sysex_fifo_busy (sysex_fifo_busy),
    .rt_valid        (rt_valid),
    .rt_data         (rt_data),
    .rt_port         (rt_port)
  );

  always #5 aclk = ~aclk;

  // Expected write event; popped = a byte was popped in the preceding cycle.
  typedef struct packed {
    logic [1:0] kind;   // 0 cmd, 1 sysex, 2 rt
    logic [7:0] a;
    logic [6:0] b;
    logic [6:0] c;
    logic       last;
    logic [3:0] port;
    logic       popped;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] pq [NP][$];
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ev_t ev_cmd(input logic [7:0] h, input logic [6:0] d1,
                                 input logic [6:0] d2, input int p);
    ev_t e;
    e = '{kind: 2'd0, a: h, b: d1, c: d2, last: 1'b0, port: 4'(p), popped: 1'b1};
    return e;
  endfunction

  function automatic ev_t ev_sx(input logic [7:0] d, input logic last, input int p,
                                input logic popped);
    ev_t e;
    e = '{kind: 2'd1, a: d, b: 7'd0, c: 7'd0, last: last, port: 4'(p), popped: popped};
    return e;
  endfunction

  function automatic ev_t ev_rt(input logic [7:0] d, input int p);
    ev_t e;
    e = '{kind: 2'd2, a: d, b: 7'd0, c: 7'd0, last: 1'b0, port: 4'(p), popped: 1'b1};
    return e;
  endfunction

  task automatic push(input int p, input logic [7:0] b);
    pq[p].push_back(b);
  endtask

  // FWFT source model: pop on in_rd sampled mid-cycle, refresh after the edge.
  initial begin
    logic [NP-1:0] rd_s;
    forever begin
      @(negedge aclk);
      rd_s = in_rd;
      @(posedge aclk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (rd_s[p] && pq[p].size() > 0) void'(pq[p].pop_front());
        in_valid[p] = (pq[p].size() > 0);
        in_data[8*p +: 8] = (pq[p].size() > 0) ? pq[p][0] : 8'h00;
      end
    end
  end

  // Monitor: compare every write strobe against the scoreboard head.
  initial begin
    logic [NP-1:0] rd_prev;
    ev_t           obs, e;
    rd_prev = '0;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        check("rd_onehot", 32'($onehot0(in_rd)), 32'd1);
        check("one_strobe", 32'($countones({cmd_fifo_wr, sysex_fifo_wr, rt_valid}) <= 1), 32'd1);
        if (cmd_fifo_wr || sysex_fifo_wr || rt_valid) begin
          if (cmd_fifo_wr)
            obs = '{kind: 2'd0, a: cmd_fifo_head, b: cmd_fifo_data1, c: cmd_fifo_data2,
                    last: 1'b0, port: 4'(cmd_fifo_port), popped: (rd_prev != '0)};
          else if (sysex_fifo_wr)
            obs = '{kind: 2'd1, a: sysex_fifo_data, b: 7'd0, c: 7'd0,
                    last: sysex_fifo_last, port: 4'(sysex_fifo_port), popped: (rd_prev != '0)};
          else
            obs = '{kind: 2'd2, a: rt_data, b: 7'd0, c: 7'd0,
                    last: 1'b0, port: 4'(rt_port), popped: (rd_prev != '0)};
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got %h expected none at %0t", 32'(obs), $time);
          end else begin
            e = exp_q.pop_front();
            check("write_event", 32'(obs), 32'(e));
          end
        end
      end
      rd_prev = in_rd;
    end
  end

  // Wait until sources and scoreboard are empty, then idle to catch strays.
  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || pq[0].size() != 0 || pq[1].size() != 0) && cyc < 300) begin
      @(negedge aclk);
      cyc++;
    end
    if (cyc >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
    end
    repeat (4) @(negedge aclk);
  endtask

  initial begin
    repeat (2) @(negedge aclk);
    check("reset_outputs",
          {8'h00, cmd_fifo_wr, sysex_fifo_wr, rt_valid, sysex_fifo_last, in_rd,
           cmd_fifo_head, sysex_fifo_data[5:0], cmd_fifo_port, sysex_fifo_port, rt_port, rt_data[0]},
          32'd0);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    check("idle_outputs", {29'd0, cmd_fifo_wr, sysex_fifo_wr, rt_valid}, 32'd0);

    // Port 0 note-on.
    exp_q.push_back(ev_cmd(8'h90, 7'h3C, 7'h64, 0));
    push(0, 8'h90); push(0, 8'h3C); push(0, 8'h64);
    wait_drain("note_on");

    // Data byte with no running status is discarded.
    push(1, 8'h45);
    wait_drain("orphan_data");

    // Program change with running status on port 1.
    exp_q.push_back(ev_cmd(8'hC5, 7'h07, 7'h00, 1));
    exp_q.push_back(ev_cmd(8'hC5, 7'h08, 7'h00, 1));
    push(1, 8'hC5); push(1, 8'h07); push(1, 8'h08);
    wait_drain("running_status");

    // Concurrent SysEx: port 0 owns the lock, port 1 waits.
    exp_q.push_back(ev_sx(8'hF0, 1'b0, 0, 1'b1));
    exp_q.push_back(ev_sx(8'h7E, 1'b0, 0, 1'b1));
    exp_q.push_back(ev_sx(8'h01, 1'b0, 0, 1'b1));
    exp_q.push_back(ev_sx(8'hF7, 1'b1, 0, 1'b1));
    exp_q.push_back(ev_sx(8'hF0, 1'b0, 1, 1'b1));
    exp_q.push_back(ev_sx(8'h11, 1'b0, 1, 1'b1));
    push(0, 8'hF0); push(0, 8'h7E); push(0, 8'h01); push(0, 8'hF7);
    push(1, 8'hF0); push(1, 8'h11);
    wait_drain("sysex_lock");
    exp_q.push_back(ev_sx(8'hF7, 1'b1, 1, 1'b1));
    push(1, 8'hF7);
    wait_drain("sysex_end_p1");

    // Realtime byte inside a channel message.
    exp_q.push_back(ev_rt(8'hF8, 0));
    exp_q.push_back(ev_cmd(8'h90, 7'h3C, 7'h40, 0));
    push(0, 8'h90); push(0, 8'hF8); push(0, 8'h3C); push(0, 8'h40);
    wait_drain("realtime");

    // Channel 0 masked off.
    @(posedge aclk); #1 ch_mask = 16'hFFFE;
    @(negedge aclk);
    exp_q.push_back(ev_cmd(8'h81, 7'h40, 7'h00, 0));
    push(0, 8'h80); push(0, 8'h40); push(0, 8'h00);
    push(0, 8'h81); push(0, 8'h40); push(0, 8'h00);
    wait_drain("ch_mask");
    @(posedge aclk); #1 ch_mask = 16'hFFFF;

    // Status inside SysEx: synthesized F7 with no pop, 90 kept for later.
    @(negedge aclk);
    exp_q.push_back(ev_sx(8'hF0, 1'b0, 0, 1'b1));
    exp_q.push_back(ev_sx(8'h01, 1'b0, 0, 1'b1));
    exp_q.push_back(ev_sx(8'hF7, 1'b1, 0, 1'b0));
    push(0, 8'hF0); push(0, 8'h01); push(0, 8'h90);
    wait_drain("sysex_abort");

    // Backpressure: no pops while either busy is high.
    @(posedge aclk); #1 cmd_fifo_busy = 1'b1;
    @(negedge aclk);
    exp_q.push_back(ev_cmd(8'h90, 7'h3C, 7'h64, 0));
    push(0, 8'h3C); push(0, 8'h64);
    repeat (4) begin
      @(negedge aclk);
      check("rd_cmd_busy", 32'(in_rd), 32'd0);
    end
    @(posedge aclk); #1 cmd_fifo_busy = 1'b0; sysex_fifo_busy = 1'b1;
    repeat (4) begin
      @(negedge aclk);
      check("rd_sysex_busy", 32'(in_rd), 32'd0);
    end
    @(posedge aclk); #1 sysex_fifo_busy = 1'b0;
    wait_drain("busy_release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
